// File: rtl/key_event_scheduler_if.sv
// Key event handshake bundle between the scheduler (master) and the
// setpoint/menu controller (slave).
interface key_event_scheduler_if #(
    parameter int KEY_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic             evt_long;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_long,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_long,
        output evt_ready
    );
endinterface

// File: rtl/key_event_scheduler.sv
// Key event scheduler: per-key hold timers produce long/repeat ticks, short
// and long requests wait in pending bits, a round-robin arbiter moves one
// request per cycle into a small event FIFO, and the FIFO head is offered
// to the consumer over valid/ready.
module key_event_scheduler #(
    parameter int N_KEYS        = 4,
    parameter int KEY_W         = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 3,
    parameter int HOLD_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_KEYS-1:0]      press,
    input  logic [N_KEYS-1:0]      stable,
    key_event_scheduler_if.master  evt,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TC     = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);
    localparam logic [KEY_W-1:0]  LAST_KEY    = KEY_W'(N_KEYS - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    logic [HOLD_W-1:0] hold_cnt [N_KEYS];
    logic [N_KEYS-1:0] tick;
    logic [N_KEYS-1:0] pend_s;
    logic [N_KEYS-1:0] pend_l;
    logic [N_KEYS-1:0] req;
    logic [N_KEYS-1:0] set_s;
    logic [N_KEYS-1:0] set_l;
    logic [N_KEYS-1:0] clr_s;
    logic [N_KEYS-1:0] clr_l;
    logic              ovf_set;

    logic [KEY_W-1:0]  rr_ptr;
    logic [KEY_W-1:0]  grant_idx;
    logic              grant_any;
    logic              grant_vld;
    logic              grant_long;

    logic [KEY_W-1:0]  key_mem  [FIFO_DEPTH];
    logic              long_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              push_ok;

    // Per-key hold timers; after the first tick they restart part way so
    // later ticks come every REPEAT_CYCLES instead of every HOLD_CYCLES.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_hold
        assign tick[i] = enable & stable[i] & (hold_cnt[i] == HOLD_TC);

        // Hold counter: runs while the key is held and the block is enabled.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_cnt[i] <= '0;
            end else if (!(enable && stable[i])) begin
                hold_cnt[i] <= '0;
            end else if (hold_cnt[i] == HOLD_TC) begin
                hold_cnt[i] <= HOLD_RELOAD;
            end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    assign pop     = evt.evt_valid & evt.evt_ready;
    assign push_ok = (fifo_count < FULL_COUNT) | pop;
    assign req     = pend_s | pend_l;
    assign set_s   = press & {N_KEYS{enable}};
    assign set_l   = tick;

    // Round-robin search from rr_ptr; scanning downward leaves the nearest
    // requester to rr_ptr as the final winner.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int j = N_KEYS - 1; j >= 0; j--) begin
            idx = (int'(rr_ptr) + j) % N_KEYS;
            if (req[KEY_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = KEY_W'(idx);
            end
        end
    end

    // Grant qualification and pending-bit clears; short is served first.
    always_comb begin
        grant_vld  = grant_any & enable & push_ok;
        grant_long = ~pend_s[grant_idx];
        clr_s      = '0;
        clr_l      = '0;
        if (grant_vld) begin
            if (pend_s[grant_idx]) begin
                clr_s[grant_idx] = 1'b1;
            end else begin
                clr_l[grant_idx] = 1'b1;
            end
        end
        ovf_set = |((set_s & pend_s & ~clr_s) | (set_l & pend_l & ~clr_l));
    end

    assign push = grant_vld;

    // Pending bits: set wins over a same-cycle grant clear; disable flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_s <= '0;
            pend_l <= '0;
        end else if (!enable) begin
            pend_s <= '0;
            pend_l <= '0;
        end else begin
            pend_s <= (pend_s & ~clr_s) | set_s;
            pend_l <= (pend_l & ~clr_l) | set_l;
        end
    end

    // Round-robin pointer moves just past the key that was granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant_idx == LAST_KEY) ? '0 : grant_idx + 1'b1;
        end
    end

    // Sticky overflow: a coalesced request wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // FIFO storage; entries are reset so the head reads zero after reset.
    for (genvar e = 0; e < FIFO_DEPTH; e++) begin : g_mem
        // Entry write on push at the write pointer.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                key_mem[e]  <= '0;
                long_mem[e] <= 1'b0;
            end else if (push && (wr_ptr == PTR_W'(e))) begin
                key_mem[e]  <= grant_idx;
                long_mem[e] <= grant_long;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign evt.evt_valid = (fifo_count != '0);
    assign evt.evt_key   = key_mem[rd_ptr];
    assign evt.evt_long  = long_mem[rd_ptr];

endmodule

// File: tb/tb_key_event_scheduler.sv
// Randomized bench for key_event_scheduler: a cycle-level reference model
// built from hold durations, pending flags and a queue produces expected
// events; a monitor compares whatever the DUT hands over.
module tb_key_event_scheduler;

    localparam int NK    = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = 100;
    localparam int REP   = 20;

    typedef struct packed {
        logic [1:0] key;
        logic       lng;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] pr;
    logic [3:0] st;
    logic [2:0] cnt;
    logic       ovf;

    key_event_scheduler_if #(.KEY_W(2)) bus ();

    key_event_scheduler dut (
        .clk          (clk),
        .reset        (rst_n),
        .enable       (en),
        .press        (pr),
        .stable       (st),
        .evt          (bus),
        .fifo_count   (cnt),
        .overflow     (ovf),
        .clr_overflow (clr)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    int  held [NK];
    bit  ps [NK];
    bit  pl [NK];
    int  rr;
    bit  movf;
    ev_t mq [$];
    ev_t sb [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            held[i] = 0;
            ps[i]   = 0;
            pl[i]   = 0;
        end
        rr   = 0;
        movf = 0;
        mq.delete();
        sb.delete();
    endtask

    // One clock of the reference behaviour, from the inputs seen at the edge.
    task automatic model_step();
        bit  pop;
        bit  tick [NK];
        int  g;
        bit  lng;
        bit  set_ovf;
        bit  cs;
        bit  cl;
        ev_t e;
        pop = (mq.size() != 0) && bus.evt_ready;
        for (int i = 0; i < NK; i++) begin
            tick[i] = en && st[i] && (held[i] + 1 >= HOLD) && (((held[i] + 1 - HOLD) % REP) == 0);
            held[i] = (en && st[i]) ? held[i] + 1 : 0;
        end
        g = -1;
        if (en && ((mq.size() < DEPTH) || pop)) begin
            for (int j = 0; j < NK; j++) begin
                int k;
                k = (rr + j) % NK;
                if (g < 0 && (ps[k] || pl[k])) g = k;
            end
        end
        lng = (g >= 0) ? !ps[g] : 1'b0;
        set_ovf = 0;
        for (int i = 0; i < NK; i++) begin
            cs = (g == i) && ps[i];
            cl = (g == i) && !ps[i];
            if (en) begin
                if (pr[i] && ps[i] && !cs) set_ovf = 1;
                if (tick[i] && pl[i] && !cl) set_ovf = 1;
                ps[i] = (ps[i] && !cs) || pr[i];
                pl[i] = (pl[i] && !cl) || tick[i];
            end else begin
                ps[i] = 0;
                pl[i] = 0;
            end
        end
        movf = set_ovf ? 1'b1 : (clr ? 1'b0 : movf);
        if (pop) void'(mq.pop_front());
        if (g >= 0) begin
            e.key = 2'(g);
            e.lng = lng;
            mq.push_back(e);
            sb.push_back(e);
            rr = (g + 1) % NK;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    // Monitor: state comparisons each cycle and scoreboard pops on handshakes.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            check("fifo_count", int'(cnt), mq.size());
            check("overflow", int'(ovf), int'(movf));
            check("evt_valid", int'(bus.evt_valid), int'(mq.size() != 0));
            if (bus.evt_valid && mq.size() != 0) begin
                check("head_key", int'(bus.evt_key), int'(mq[0].key));
                check("head_long", int'(bus.evt_long), int'(mq[0].lng));
            end
            if (bus.evt_valid && bus.evt_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("evt_key", int'(bus.evt_key), int'(e.key));
                    check("evt_long", int'(bus.evt_long), int'(e.lng));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.evt_valid), 0);
        check({tag, "_key"}, int'(bus.evt_key), 0);
        check({tag, "_long"}, int'(bus.evt_long), 0);
        check({tag, "_count"}, int'(cnt), 0);
        check({tag, "_overflow"}, int'(ovf), 0);
    endtask

    task automatic tick_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        pr    = '0;
        st    = '0;
        bus.evt_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        tick_cycles(3);
        rst_n = 1'b1;
        en    = 1'b1;

        // Single press of key 2 with the consumer ready.
        bus.evt_ready = 1'b1;
        pr = 4'b0100;
        tick_cycles(1);
        pr = '0;
        tick_cycles(5);

        // Simultaneous presses with the consumer stalled, then drained.
        bus.evt_ready = 1'b0;
        pr = 4'b1011;
        tick_cycles(1);
        pr = '0;
        tick_cycles(4);
        pr = 4'b0011;
        tick_cycles(1);
        pr = '0;
        tick_cycles(3);
        bus.evt_ready = 1'b1;
        tick_cycles(10);

        // Key 1 held for 145 cycles: long events at 100, 120, 140.
        st = 4'b0010;
        tick_cycles(145);
        st = '0;
        tick_cycles(30);

        // Fill the FIFO, leave one request pending, repeat it, then clear.
        bus.evt_ready = 1'b0;
        for (int i = 0; i < NK; i++) begin
            pr = 4'(1 << i);
            tick_cycles(1);
        end
        pr = 4'b0001;
        tick_cycles(1);
        pr = '0;
        tick_cycles(2);
        pr = 4'b0001;
        tick_cycles(1);
        pr = '0;
        tick_cycles(2);
        bus.evt_ready = 1'b1;
        tick_cycles(10);
        clr = 1'b1;
        tick_cycles(1);
        clr = 1'b0;
        tick_cycles(3);

        // Disabled: presses and long holds are ignored while the queue drains.
        bus.evt_ready = 1'b0;
        pr = 4'b0110;
        tick_cycles(1);
        pr = '0;
        tick_cycles(2);
        en = 1'b0;
        bus.evt_ready = 1'b1;
        st = 4'b1001;
        for (int c = 0; c < 200; c++) begin
            pr = 4'($urandom_range(0, 15));
            tick_cycles(1);
        end
        pr = '0;
        st = '0;
        en = 1'b1;
        tick_cycles(5);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NK; i++) begin
                pr[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 199) == 0) st[i] = ~st[i];
            end
            if ((c % 500) >= 440) bus.evt_ready = 1'b0;
            else bus.evt_ready = ($urandom_range(0, 3) != 0);
            en  = !(c >= 1500 && c < 1620);
            clr = ($urandom_range(0, 49) == 0);
            if (c == 2500) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                model_reset();
                tick_cycles(2);
                rst_n = 1'b1;
            end else begin
                tick_cycles(1);
            end
        end

        // Final drain: every expected event must have been delivered.
        pr  = '0;
        st  = '0;
        clr = 1'b0;
        en  = 1'b1;
        bus.evt_ready = 1'b1;
        tick_cycles(30);
        check("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
